// File: rtl/up_down_counter.sv
// WIDTH-bit up/down counter with synchronous load, terminal-count flag and wrap pulse.
// Define UP_DOWN_COUNTER_SAT_EN to saturate at the limits instead of wrapping (wrap stays 0).
module up_down_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] MAX  = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_lim;

  // The counter is at the boundary it is about to cross in the current direction.
  assign at_lim = up_dn ? (cnt_q == MAX) : (cnt_q == '0);
  assign tc     = en & at_lim;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (at_lim) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d  = up_dn ? '0 : MAX;
        wrap_d = 1'b1;
`endif
      end else begin
        cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= INIT;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: a reference model pushes expected out/wrap
// into a queue as each step is driven; the entry is popped after the clock edge.
module tb_up_down_counter;
  localparam int W = 4;
  localparam logic [W-1:0] MAX = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         tc, wrap;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrp;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] m_cnt;

  up_down_counter #(.WIDTH(W), .INIT_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .out(out), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check tc combinationally,
  // then compare the registered result just after the rising edge.
  task automatic step(input string tag, input logic e, input logic u, input logic l,
                      input logic [W-1:0] lv);
    exp_t nx;
    logic exp_tc;
    en = e; up_dn = u; load = l; load_val = lv;
    #1;
    exp_tc = e && (u ? (m_cnt == MAX) : (m_cnt == '0));
    chk({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    nx.wrp = 1'b0;
    if (l) nx.cnt = lv;
    else if (!e) nx.cnt = m_cnt;
    else if (u && m_cnt == MAX) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
      nx.cnt = MAX;
`else
      nx.cnt = '0; nx.wrp = 1'b1;
`endif
    end else if (!u && m_cnt == '0) begin
`ifdef UP_DOWN_COUNTER_SAT_EN
      nx.cnt = '0;
`else
      nx.cnt = MAX; nx.wrp = 1'b1;
`endif
    end else nx.cnt = u ? m_cnt + 1'b1 : m_cnt - 1'b1;
    sb.push_back(nx);
    m_cnt = nx.cnt;
    @(posedge clk); #1;
    if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    else begin
      nx = sb.pop_front();
      chk({tag, ".out"},  32'(out),  32'(nx.cnt));
      chk({tag, ".wrap"}, 32'(wrap), 32'(nx.wrp));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
    m_cnt = '0;
    #1;
    chk("rst0.out", 32'(out), 32'd0);
    chk("rst0.wrap", 32'(wrap), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_edge.out", 32'(out), 32'd0);
      chk("rst_edge.wrap", 32'(wrap), 32'd0);
    end
    @(negedge clk);               // 30ns
    rst = 1'b1;
    step("up1", 1, 1, 0, '0);
    step("up2", 1, 1, 0, '0);
    step("up3", 1, 1, 0, '0);

    // Asynchronous clear between edges (60ns)
    rst = 1'b0;
    #1;
    chk("async.out", 32'(out), 32'd0);
    m_cnt = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("async_hold.out", 32'(out), 32'd0);
      chk("async_hold.wrap", 32'(wrap), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Up wrap: 14, 15, 0, 1
    step("ld14", 0, 1, 1, 4'd14);
    step("upw15", 1, 1, 0, 'x);
    step("upw0", 1, 1, 0, 'x);
    step("upw1", 1, 1, 0, 'x);

    // Down wrap: 1, 0, 15, 14
    step("ld1", 1, 0, 1, 4'd1);
    step("dn0", 1, 0, 0, '0);
    step("dn15", 1, 0, 0, '0);
    step("dn14", 1, 0, 0, '0);

    for (int i = 0; i < 5; i++) step("hold", 0, 1, 0, 'x);
    step("hold_dn", 0, 0, 0, '0);

    // Load wins over count enable
    step("ld5", 0, 1, 1, 4'd5);
    step("ld9_pri", 1, 1, 1, 4'd9);
    step("up10", 1, 1, 0, 'x);

    // Upper limit: wraps by default, saturates with the option
    step("ld15", 0, 1, 1, 4'd15);
    step("lim_up", 1, 1, 0, '0);
    step("lim_up2", 1, 1, 0, '0);
    step("ld0", 0, 0, 1, 4'd0);
    step("lim_dn", 1, 0, 0, '0);
    step("ld_over", 1, 1, 1, 4'd3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Synchronous binary counter: WIDTH-bit count value, one clock domain, asynchronous active-low reset.
- Counts up or down when enabled, supports synchronous parallel load, and flags terminal count and wrap-around.
- General-purpose timing/sequence source for control logic; default configuration is a free-running 4-bit up counter.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- INIT_VAL, 0, value forced onto out while reset is asserted; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- en  input  1  count enable; 1 = count on the next rising clk edge.
- up_dn  input  1  direction; 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value captured when load=1.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  one-cycle registered pulse after a wrap-around.

Behaviour:
- Reset:
  - While rst=0, out=INIT_VAL and wrap=0, immediately, with no clock edge required.
  - rst may assert at any time, including mid-count; the clear takes effect asynchronously.
  - Deassertion is sampled on clk; the first count occurs on the first rising edge with rst=1.
- Priority on each rising clk edge (rst=1): load > en > hold.
  - load=1: out <= load_val, regardless of en or up_dn; wrap <= 0.
  - load=0, en=1, up_dn=1: out <= out+1, modulo 2^WIDTH.
  - load=0, en=1, up_dn=0: out <= out-1, modulo 2^WIDTH.
  - load=0, en=0: out holds; wrap <= 0.
- Wrap-around:
  - Up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1.
  - wrap <= 1 for exactly the one cycle after the edge that performed the wrap, else 0.
- tc = en & (up_dn ? out==2^WIDTH-1 : out==0). It is high in the cycle before a wrap, and tc=0 when en=0.
- All arithmetic is unsigned WIDTH-bit. No X propagation from load_val when load=0.
- Latency: one clock from en/load sampled to new out value; tc has zero latency relative to out/en/up_dn.
- Default-use tie-offs for a free-running up counter: en=1, up_dn=1, load=0, load_val=0.

Optional Feature:
- Macro: UP_DOWN_COUNTER_SAT_EN.
- Defined:
  - Counter saturates instead of wrapping: up at 2^WIDTH-1 holds at 2^WIDTH-1, down at 0 holds at 0.
  - wrap is never asserted (tied 0).
  - tc behaviour is unchanged, so it still indicates the limit.
  - load still overrides saturation.
- Not defined: modulo wrap-around as described in Behaviour.

Test Plan:
- Reset: hold rst=0 from t=0 to 30ns, 10ns clk period, en=1, up_dn=1 -> out=0 and wrap=0 throughout, including across clock edges.
- Count up: release rst at 30ns -> out=1,2,3 on the rising edges at 35, 45, 55ns.
- Async reset mid-count: drive rst=0 at 60ns (between edges) -> out=0 immediately at 60ns; holds 0 on all following edges while rst=0.
- Up wrap: load_val=14 with load=1 for one edge, then en=1, up_dn=1 ->
  - sequence 14, 15, 0, 1;
  - tc=1 while out=15;
  - wrap=1 exactly while out=0 right after the wrap.
- Down count: load 1, then en=1, up_dn=0 ->
  - sequence 1, 0, 15, 14;
  - tc=1 while out=0;
  - wrap pulse while out=15.
  - Separately, en=0 -> out holds 14 over 5 edges with tc=0.
- Load priority and saturation: out=5, load=1, load_val=9, en=1 -> out=9, not 6. With UP_DOWN_COUNTER_SAT_EN defined, counting up from 15 -> out stays 15 and wrap stays 0.
